// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op-code encoding (same as the
// parallel ALU) and the sequencer state encoding.
package serial_alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes 0..3 are arithmetic (0/2 add, 1/3 subtract); 4..7 are bitwise.
  function automatic logic is_arith(input logic [2:0] ctrl);
    return ~ctrl[2];
  endfunction

endpackage

// File: rtl/serial_alu_alu1.sv
// One-bit ALU slice. Arithmetic ops use a full adder with B inverted for
// subtraction (control[0]=1); bitwise ops report a carry-out of 0.
module alu1
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic [2:0] control,
  output logic       result,
  output logic       carryout
);

  logic b_eff_s;

  assign b_eff_s = b ^ control[0];

  // Per-bit function select and full-adder carry.
  always_comb begin
    result   = 1'b0;
    carryout = 1'b0;
    case (control)
      3'd0, 3'd1, ALU_ADD, ALU_SUB: begin
        result   = a ^ b_eff_s ^ carryin;
        carryout = (a & b_eff_s) | (a & carryin) | (b_eff_s & carryin);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_XOR: result = a ^ b;
      default: begin
        result   = 1'b0;
        carryout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU sequencer: feeds one alu1 slice LSB first, one bit per cycle,
// with a registered carry chain; result and flags appear WIDTH+1 cycles after
// start is accepted.
// Build option: define SERIAL_ALU_FLAGS_EN to enable the zero / negative /
// overflow / carryout flags; otherwise those outputs are tied to 0.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, out_q;
  logic [WIDTH-1:0] res_next_s;
  logic [2:0]       ctrl_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             accept_s, last_s;
  logic             slice_res_s, slice_cout_s;

  assign accept_s   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_s     = (state_q == ST_RUN) && (cnt_q == LAST_BIT);
  assign res_next_s = {slice_res_s, res_q[WIDTH-1:1]};

  alu1 u_slice (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .carryin  (carry_q),
    .control  (ctrl_q),
    .result   (slice_res_s),
    .carryout (slice_cout_s)
  );

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_q == LAST_BIT) state_d = ST_DONE;
        else                   state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Operand shifters, carry chain, bit counter and result accumulation.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      ctrl_q  <= 3'd0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept_s) begin
      a_sh_q  <= A;
      b_sh_q  <= B;
      ctrl_q  <= control;
      carry_q <= control[0];
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
      res_q   <= res_next_s;
      carry_q <= slice_cout_s;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Result word: updated only when the last bit has been produced.
  always_ff @(posedge clock) begin
    if (reset)       out_q <= '0;
    else if (last_s) out_q <= res_next_s;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

`ifdef SERIAL_ALU_FLAGS_EN
  logic cin_msb_q, cout_q, zero_q, neg_q;

  // Flags captured on entry to DONE; carries are gated to 0 for bitwise ops,
  // so overflow (carry-in XOR carry-out of the MSB slice) is 0 for them too.
  always_ff @(posedge clock) begin
    if (reset) begin
      cin_msb_q <= 1'b0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
    end else if (last_s) begin
      cin_msb_q <= is_arith(ctrl_q) & carry_q;
      cout_q    <= is_arith(ctrl_q) & slice_cout_s;
      zero_q    <= (res_next_s == '0);
      neg_q     <= res_next_s[WIDTH-1];
    end
  end

  assign carryout = cout_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign overflow = cin_msb_q ^ cout_q;
`else
  assign carryout = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=32): directed vector table,
// hand sequences for start-during-RUN, mid-RUN reset and back-to-back ops,
// then random ops against an arithmetic reference model.
module tb_serial_alu;
  import serial_alu_pkg::*;

  localparam int W = 32;
`ifdef SERIAL_ALU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [W-1:0] A, B;
  logic [2:0]   control;
  logic         busy, done, carryout, zero, negative, overflow;
  logic [W-1:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
    .control(control), .busy(busy), .done(done), .out(out),
    .carryout(carryout), .zero(zero), .negative(negative), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [3:0] mask(input logic [3:0] f);
    return FL ? f : 4'b0000;
  endfunction

  // Reference: flags {carryout, overflow, negative, zero} from plain arithmetic.
  task automatic model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] fl);
    longint sa, sb, t;
    logic cy, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t = 0; cy = 1'b0; v = 1'b0;
    case (c)
      3'd0, 3'd2: begin
        t = sa + sb; r = a + b;
        cy = ({32'b0, a} + {32'b0, b}) > 64'h00000000FFFFFFFF;
        v = (t > SMAX) || (t < SMIN);
      end
      3'd1, 3'd3: begin
        t = sa - sb; r = a - b;
        cy = (a >= b);
        v = (t > SMAX) || (t < SMIN);
      end
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = ~(a | b);
      default: r = a ^ b;
    endcase
    fl = mask({cy, v, r[W-1], (r == '0)});
  endtask

  // Issue one op from IDLE/DONE and wait (bounded) for done.
  task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [3:0] fl,
                        output int lat, output bit busy_ok);
    @(negedge clock);
    start = 1'b1; control = c; A = a; B = b;
    @(negedge clock);
    start = 1'b0; A = $urandom; B = $urandom; control = 3'($urandom_range(7, 0));
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    r  = out;
    fl = {carryout, overflow, negative, zero};
  endtask

  typedef struct {
    logic [2:0]   c;
    logic [W-1:0] a, b, r;
    logic [3:0]   fl;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [W-1:0] r, er;
    logic [3:0]   fl, efl;
    int           lat, ndone, dk, first, second;
    bit           bok;

    tbl[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110};
    tbl[1]  = '{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1001};
    tbl[2]  = '{ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0010};
    tbl[3]  = '{ALU_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 4'b0000};
    tbl[4]  = '{ALU_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0010};
    tbl[5]  = '{ALU_AND, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 4'b0000};
    tbl[6]  = '{ALU_OR,  32'h00FF00FF, 32'h0F0F0000, 32'h0FFF00FF, 4'b0000};
    tbl[7]  = '{3'd0,    32'h00000002, 32'h00000003, 32'h00000005, 4'b0000};
    tbl[8]  = '{3'd1,    32'h0000000A, 32'h00000003, 32'h00000007, 4'b1000};
    tbl[9]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001};
    tbl[10] = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100};
    tbl[11] = '{ALU_XOR, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0001};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; control = 3'd0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", out, 32'h0);
    check("rst_flags", {carryout, overflow, negative, zero}, mask(4'b0001));
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, r, fl, lat, bok);
      check($sformatf("vec%0d_out", i), r, tbl[i].r);
      check($sformatf("vec%0d_flags", i), fl, mask(tbl[i].fl));
      check($sformatf("vec%0d_latency", i), lat, 33);
      check($sformatf("vec%0d_busy", i), bok, 1'b1);
    end

    // start pulsed during RUN must be ignored.
    @(negedge clock);
    start = 1'b1; control = ALU_ADD; A = 32'd1; B = 32'd1;
    ndone = 0; dk = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (k == 1)  start = 1'b0;
      if (done) begin ndone++; dk = k; r = out; end
      if (k == 10) begin start = 1'b1; A = 32'd100; end
      if (k == 11) start = 1'b0;
    end
    check("ignore_start_ndone", ndone, 1);
    check("ignore_start_at", dk, 33);
    check("ignore_start_out", r, 32'd2);

    // Reset in the middle of RUN aborts the op.
    @(negedge clock);
    start = 1'b1; control = ALU_ADD; A = 32'd5; B = 32'd6;
    ndone = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 17) begin
        check("midrst_busy", busy, 1'b0);
        check("midrst_out", out, 32'h0);
        check("midrst_flags", {carryout, overflow, negative, zero}, mask(4'b0001));
        reset = 1'b0;
      end
      if (done) ndone++;
      if (k == 16) reset = 1'b1;
    end
    check("midrst_no_done", ndone, 0);
    run_op(ALU_ADD, 32'd3, 32'd4, r, fl, lat, bok);
    check("after_rst_out", r, 32'd7);
    check("after_rst_latency", lat, 33);

    // start held high: two back-to-back ops.
    @(negedge clock);
    start = 1'b1; control = ALU_ADD; A = 32'd1; B = 32'd2;
    first = 0; second = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (first != 0 && k == first + 1) check("b2b_busy_rise", busy, 1'b1);
      if (done && first == 0) begin
        first = k;
        check("b2b_out1", out, 32'd3);
        A = 32'd9; B = 32'd4; control = ALU_SUB;
      end else if (done && second == 0) begin
        second = k;
        check("b2b_out2", out, 32'd5);
        check("b2b_flags2", {carryout, overflow, negative, zero}, mask(4'b1000));
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_first_at", first, 33);
    check("b2b_spacing", second - first, 33);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   c;
      logic [W-1:0] a, b;
      c = 3'($urandom_range(7, 0));
      a = (i % 5 == 0) ? 32'h7FFFFFFF : W'($urandom);
      b = (i % 7 == 0) ? 32'h80000000 : W'($urandom);
      if (i % 9 == 0) b = a;
      model(c, a, b, er, efl);
      run_op(c, a, b, r, fl, lat, bok);
      check($sformatf("rnd%0d_out", i), r, er);
      check($sformatf("rnd%0d_flags", i), fl, efl);
      check($sformatf("rnd%0d_latency", i), lat, 33);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
